// File: rtl/gray_tx_pkg.sv
// Shared definitions for the Gray-coded byte transmitter: byte width,
// FSM state encoding and the binary-to-Gray encoder used at frame capture.
package gray_tx_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2,
    GAP   = 2'd3
  } tx_state_t;

  // g[7] = b[7]; g[i] = b[i+1] ^ b[i] for the lower bits.
  function automatic logic [BYTE_W-1:0] bin2gray(input logic [BYTE_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_byte_tx.sv
// gray_byte_tx: accepts a two-byte binary frame, Gray-encodes both bytes at
// capture and serialises them (byte 0, then byte 1) on an 8-bit link, with
// GAP_CYCLES idle cycles forced after every frame.
//
// Optional feature macro: GRAY_TX_PARITY_EN adds parity_out = ^data_out.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid && ready are both high. The producer holds valid and its payload
// stable until that edge; ready may be high with valid low.
// in_ready is a register (high only in IDLE, low during reset and for the
// first edge after it). out_valid / data_out / out_last / parity_out are
// decoded from the state register and the capture registers g0/g1, so there
// is no combinational path from any input to any output.
module gray_byte_tx
  import gray_tx_pkg::*;
#(
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] BD_DATA_0,
  input  logic [BYTE_W-1:0] BD_DATA_1,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
`ifdef GRAY_TX_PARITY_EN
  output logic              parity_out,
`endif
  output logic [1:0]        state_dbg
);

  // Counter needs at least one bit even when the gap is disabled.
  localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  tx_state_t         state;
  tx_state_t         state_d;
  logic [BYTE_W-1:0] g0;
  logic [BYTE_W-1:0] g1;
  logic [CNT_W-1:0]  gap_cnt;
  logic              accept;

  assign accept    = (state == IDLE) && in_valid && in_ready;
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state logic; the gap is skipped entirely when GAP_CYCLES is 0.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (accept) state_d = SEND0;
      SEND0: if (out_ready) state_d = SEND1;
      SEND1: if (out_ready) state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:   if (gap_cnt == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from state and capture registers.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    data_out  = '0;
    busy      = (state != IDLE);
    case (state)
      SEND0: begin
        out_valid = 1'b1;
        data_out  = g0;
      end
      SEND1: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        data_out  = g1;
      end
      default: ;
    endcase
  end

`ifdef GRAY_TX_PARITY_EN
  // data_out is forced to 0 when idle, so parity is already qualified.
  assign parity_out = ^data_out;
`endif

  // in_ready is registered from the next state so it never follows in_valid
  // combinationally and stays low during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_ready <= 1'b0;
    else     in_ready <= (state_d == IDLE);
  end

  // Capture and encode both bytes when a frame is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g0 <= '0;
      g1 <= '0;
    end else if (accept) begin
      g0 <= bin2gray(BD_DATA_0);
      g1 <= bin2gray(BD_DATA_1);
    end
  end

  // Gap counter: loaded on entry to GAP, counts down to zero, no wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (state != GAP && state_d == GAP) begin
      gap_cnt <= GAP_LOAD;
    end else if (state == GAP && gap_cnt != '0) begin
      gap_cnt <= gap_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gray_byte_tx.sv
// Bench for gray_byte_tx (GAP_CYCLES = 3). Expected link words
// {out_last, data_out} are queued when a frame is accepted; a negedge
// monitor pops and compares on every out_valid && out_ready.
module tb_gray_byte_tx;

  localparam int GAP = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bd0 = 8'h00;
  logic [7:0] bd1 = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] data_out;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic [1:0] state_dbg;
`ifdef GRAY_TX_PARITY_EN
  logic       parity_out;
`endif

  logic rand_rdy  = 1'b0;
  logic fixed_rdy = 1'b0;
  logic rnd_bit   = 1'b1;
  assign out_ready = rand_rdy ? rnd_bit : fixed_rdy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_w;
  logic       hold_v = 1'b0;
  logic [8:0] hold_w = '0;
  int         cap1, cap2, capx;

  gray_byte_tx #(.GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .BD_DATA_0 (bd0),
    .BD_DATA_1 (bd1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
`ifdef GRAY_TX_PARITY_EN
    .parity_out(parity_out),
`endif
    .state_dbg (state_dbg)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Random back-pressure source, changes just after each rising edge.
  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  function automatic logic [7:0] ref_gray(input logic [7:0] b);
    ref_gray = b ^ {1'b0, b[7:1]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", out_valid, 1);
        check("hold_word", {out_last, data_out}, hold_w);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_byte: got %0h expected nothing", {out_last, data_out});
        end else begin
          mon_w = exp_q.pop_front();
          check("link_word", {out_last, data_out}, mon_w);
`ifdef GRAY_TX_PARITY_EN
          check("parity", parity_out, ^mon_w[7:0]);
`endif
        end
      end
      if (!out_valid) begin
        check("idle_word", {out_last, data_out}, 0);
`ifdef GRAY_TX_PARITY_EN
        check("idle_parity", parity_out, 0);
`endif
      end
      hold_v = out_valid && !out_ready;
      hold_w = {out_last, data_out};
    end
  end

  // Offer a frame, wait (bounded) for acceptance, queue the expected bytes.
  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] e0, input logic [7:0] e1,
                            output int cap_cyc);
    bit ok;
    ok = 1'b0;
    cap_cyc = cyc;
    bd0 = b0;
    bd1 = b1;
    in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    cap_cyc = cyc;
    exp_q.push_back({1'b0, e0});
    exp_q.push_back({1'b1, e1});
    #1;
    in_valid = 1'b0;
    bd0 = 8'($urandom);
    bd1 = 8'($urandom);
  endtask

  // Wait (bounded) for the scoreboard to empty; ends just after a rising edge.
  task automatic wait_drain(input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < max_cyc; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d queued expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  // Directed and random stimulus.
  initial begin
    // Reset values.
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_data_out", data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("in_ready_before_edge", in_ready, 0);
    @(posedge clk);
    #1;
    check("in_ready_after_edge", in_ready, 1);

    // Basic frame, latency one edge after capture.
    fixed_rdy = 1'b1;
    send_frame(8'hA5, 8'h3C, 8'hF7, 8'h22, capx);
    @(negedge clk);
    check("t1_byte0", {out_valid, out_last, data_out}, {2'b10, 8'hF7});
    @(negedge clk);
    check("t1_byte1", {out_valid, out_last, data_out}, {2'b11, 8'h22});
    wait_drain(50);

    // Back-pressure held for 4 cycles in SEND0.
    fixed_rdy = 1'b0;
    send_frame(8'hFF, 8'h80, 8'h80, 8'hC0, capx);
    repeat (4) begin
      @(negedge clk);
      check("t2_hold_valid", out_valid, 1);
      check("t2_hold_data", data_out, 8'h80);
      check("t2_in_ready_low", in_ready, 0);
    end
    @(posedge clk);
    #1;
    fixed_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t2_byte1", {out_valid, out_last, data_out}, {2'b11, 8'hC0});
    wait_drain(50);

    // Back-to-back frames: capture spacing is 3 + GAP.
    send_frame(8'h11, 8'h22, 8'h19, 8'h33, cap1);
    send_frame(8'h33, 8'h44, 8'h2A, 8'h66, cap2);
    check("t3_frame_period", cap2 - cap1, 3 + GAP);
    wait_drain(50);

    // Asynchronous reset during SEND1.
    fixed_rdy = 1'b0;
    send_frame(8'h12, 8'h34, 8'h1B, 8'h2E, capx);
    @(posedge clk);
    #1;
    fixed_rdy = 1'b1;
    @(posedge clk);
    #1;
    fixed_rdy = 1'b0;
    check("t4_byte0_consumed", exp_q.size(), 1);
    check("t4_in_send1", {out_valid, out_last}, 2'b11);
    #1;
    rst = 1'b1;
    #1;
    check("t4_async_valid", out_valid, 0);
    check("t4_async_last", out_last, 0);
    check("t4_async_data", data_out, 0);
    check("t4_async_busy", busy, 0);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t4_in_ready_release", in_ready, 0);
    @(posedge clk);
    #1;
    check("t4_in_ready_back", in_ready, 1);
    fixed_rdy = 1'b1;
    send_frame(8'h00, 8'h05, 8'h00, 8'h07, capx);
    @(negedge clk);
    check("t4_byte0", {out_valid, out_last, data_out}, {2'b10, 8'h00});
    @(negedge clk);
    check("t4_byte1", {out_valid, out_last, data_out}, {2'b11, 8'h07});
    wait_drain(50);

`ifdef GRAY_TX_PARITY_EN
    // Parity follows the encoded byte.
    send_frame(8'hA5, 8'h00, 8'hF7, 8'h00, capx);
    @(negedge clk);
    check("t5_parity0", {parity_out, data_out}, {1'b1, 8'hF7});
    @(negedge clk);
    check("t5_parity1", {parity_out, data_out}, {1'b0, 8'h00});
    wait_drain(50);
`endif

    // Random frames under random back-pressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] r0, r1;
      r0 = 8'($urandom_range(0, 255));
      r1 = 8'($urandom_range(0, 255));
      send_frame(r0, r1, ref_gray(r0), ref_gray(r1), capx);
    end
    wait_drain(500);
    rand_rdy = 1'b0;
    fixed_rdy = 1'b0;
    repeat (GAP + 2) @(posedge clk);
    #1;
    check("end_idle_busy", busy, 0);
    check("end_in_ready", in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
